exe_issue_ctrl: RTL and testbench
=================================

Name: exe_issue_ctrl

Overview:
- Upstream issue stage for the execution unit.
- Buffers operation requests {oper, argA, argB} from a producer in a small FIFO with a valid/ready handshake.
- Drives the execution unit's operand inputs from registers, then presents the unit's registered result/status downstream with a valid/ready handshake.
- Keeps at most one operation in flight, because the execution unit re-registers its inputs on every clock edge. Also counts results that carry a non-zero status.

Parameters:
- m, 4, operand/result width (matches execution unit m)
- n, 2, opcode width (matches execution unit n)
- DEPTH, 4, request FIFO entries (power of two, >=2)
- CW, 8, error counter width

Ports:
- i_clk  in  1  clock, rising edge
- i_rsn  in  1  asynchronous active-low reset
- i_valid  in  1  producer request valid
- o_ready  out  1  FIFO can accept (= !full)
- i_oper  in  n  requested opcode
- i_argA  in  m  requested operand A
- i_argB  in  m  requested operand B
- o_oper  out  n  opcode to execution unit (registered)
- o_argA  out  m  operand A to execution unit (registered)
- o_argB  out  m  operand B to execution unit (registered)
- i_exe_result  in  m  execution unit o_result
- i_exe_status  in  2  execution unit o_status
- o_res_valid  out  1  downstream result valid
- i_res_ready  in  1  downstream accepts result
- o_result  out  m  = i_exe_result when o_res_valid, else 0
- o_status  out  2  = i_exe_status when o_res_valid, else 0
- o_level  out  $clog2(DEPTH)+1  FIFO occupancy
- o_err_cnt  out  CW  accepted results with status != 2'b00

Behaviour:
- Clocking and reset: one clock i_clk; reset i_rsn is asynchronous, active-low.
- Reset values:
  - FIFO empty, o_level=0, o_ready=1
  - state IDLE
  - o_oper/o_argA/o_argB = 0
  - o_res_valid=0, o_err_cnt=0
- Reset mid-operation discards queued and in-flight ops; no result is emitted for them.
- Push: the FIFO writes on the edge where i_valid && o_ready.
  - Full: o_ready=0; the request is not taken and the producer holds.
- Pop: loads the head into the operand registers on the same edge, level decrements.
  - Push and pop on one edge leave the level unchanged.
  - Pointers wrap modulo DEPTH.
- FSM:
  - IDLE: operands hold their last values. If level>0: pop, go to ISSUE.
  - ISSUE (exactly 1 cycle): operands are stable; the execution unit samples them on the exiting edge. Go to RESULT.
  - RESULT:
    - o_res_valid=1; o_result/o_status pass through combinationally from i_exe_*.
    - Operands are held, so the execution unit re-registers identical values and its output stays stable.
    - If i_res_ready && level>0: pop, go to ISSUE.
    - If i_res_ready && level==0: go to IDLE.
    - Else stay in RESULT.
- Latency and throughput:
  - Push edge to o_res_valid: 3 edges when the FIFO was empty and the FSM was IDLE.
  - Best throughput is one result per 2 cycles.
- o_err_cnt increments on each result handshake (o_res_valid && i_res_ready) with o_status != 0. It saturates at 2^CW-1.
- o_res_valid, o_result and o_status must not change while o_res_valid && !i_res_ready.
- A push arriving in the same cycle as the RESULT->ISSUE pop is accepted normally.

Test Plan:
All scenarios use m=4, n=2, DEPTH=4, CW=8. The bench stub is a registered execution unit: result = argA ^ argB, status = 2'b01 when oper==2'b11, else 2'b00.
1. Single op: push {oper=0,A=4'h5,B=4'h3}, i_res_ready=1 -> o_res_valid high exactly 3 edges after the push for 1 cycle, o_result=4'h6, o_status=0, FSM returns to IDLE.
2. Backpressure: same op, i_res_ready=0 for 5 cycles -> o_res_valid=1, o_result=4'h6 steady, o_oper/o_argA/o_argB unchanged; accepted on the first cycle ready=1.
3. FIFO full: 5 back-to-back pushes with i_res_ready=0 -> first pops into operands, next 4 fill FIFO, o_level=4, o_ready=0 after 5th accepted; 6th request held; all 5 results later emerge in order.
4. Throughput: 4 queued ops, i_res_ready=1 -> valid pulses every 2 cycles, results in push order, o_level 4->0.
5. Error count: 3 ops with oper=2'b11 and 1 with oper=0 accepted -> o_err_cnt=3. Preload 255 ops with oper=2'b11 -> count holds at 8'hFF.
6. Reset mid-op: assert i_rsn=0 during RESULT with 2 queued -> outputs immediately at reset values; after release no stale result emitted, o_level=0.

Source files
------------

// File: rtl/exe_issue_ctrl.sv
// Issue stage in front of a registered execution unit.
// Requests are queued in a small FIFO, issued one at a time to the unit's
// operand registers, and the unit's result/status is handed downstream with
// a valid/ready handshake. Results with a non-zero status are counted.
module exe_issue_ctrl #(
    parameter int m     = 4,
    parameter int n     = 2,
    parameter int DEPTH = 4,
    parameter int CW    = 8
) (
    input  logic                       i_clk,
    input  logic                       i_rsn,
    input  logic                       i_valid,
    output logic                       o_ready,
    input  logic [n-1:0]               i_oper,
    input  logic [m-1:0]               i_argA,
    input  logic [m-1:0]               i_argB,
    output logic [n-1:0]               o_oper,
    output logic [m-1:0]               o_argA,
    output logic [m-1:0]               o_argB,
    input  logic [m-1:0]               i_exe_result,
    input  logic [1:0]                 i_exe_status,
    output logic                       o_res_valid,
    input  logic                       i_res_ready,
    output logic [m-1:0]               o_result,
    output logic [1:0]                 o_status,
    output logic [$clog2(DEPTH):0]     o_level,
    output logic [CW-1:0]              o_err_cnt
);

    localparam int AW = $clog2(DEPTH);
    localparam int LW = AW + 1;
    localparam int EW = n + 2 * m;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ISSUE  = 2'd1,
        RESULT = 2'd2
    } state_t;

    state_t          state;
    state_t          state_nxt;
    logic [EW-1:0]   mem [DEPTH];
    logic [AW-1:0]   wr_ptr;
    logic [AW-1:0]   rd_ptr;
    logic [LW-1:0]   level;
    logic            push;
    logic            pop;
    logic            res_hs;

    assign o_ready     = (level != LW'(DEPTH));
    assign push        = i_valid && o_ready;
    assign o_level     = level;
    assign o_res_valid = (state == RESULT);
    assign o_result    = o_res_valid ? i_exe_result : '0;
    assign o_status    = o_res_valid ? i_exe_status : 2'b00;
    assign res_hs      = o_res_valid && i_res_ready;

    // Next-state and pop decision: only one operation may be in flight.
    always_comb begin
        state_nxt = state;
        pop       = 1'b0;
        case (state)
            IDLE: begin
                if (level != '0) begin
                    pop       = 1'b1;
                    state_nxt = ISSUE;
                end
            end
            ISSUE: begin
                state_nxt = RESULT;
            end
            RESULT: begin
                if (i_res_ready) begin
                    if (level != '0) begin
                        pop       = 1'b1;
                        state_nxt = ISSUE;
                    end else begin
                        state_nxt = IDLE;
                    end
                end
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    // State register.
    always_ff @(posedge i_clk or negedge i_rsn) begin
        if (!i_rsn) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // FIFO storage; contents are don't-care until written, so no reset.
    always_ff @(posedge i_clk) begin
        if (push) begin
            mem[wr_ptr] <= {i_oper, i_argA, i_argB};
        end
    end

    // FIFO pointers and occupancy; pointers wrap naturally at DEPTH.
    always_ff @(posedge i_clk or negedge i_rsn) begin
        if (!i_rsn) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            level <= level + LW'(push) - LW'(pop);
        end
    end

    // Operand registers load the FIFO head on a pop and hold otherwise.
    always_ff @(posedge i_clk or negedge i_rsn) begin
        if (!i_rsn) begin
            o_oper <= '0;
            o_argA <= '0;
            o_argB <= '0;
        end else if (pop) begin
            {o_oper, o_argA, o_argB} <= mem[rd_ptr];
        end
    end

    // Saturating count of accepted results with non-zero status.
    always_ff @(posedge i_clk or negedge i_rsn) begin
        if (!i_rsn) begin
            o_err_cnt <= '0;
        end else if (res_hs && (o_status != 2'b00) && (o_err_cnt != '1)) begin
            o_err_cnt <= o_err_cnt + CW'(1);
        end
    end

endmodule

// File: tb/tb_exe_issue_ctrl.sv
// Scoreboard bench for exe_issue_ctrl with a registered execution-unit stub
// (result = argA ^ argB, status = 01 when oper == 11).
module tb_exe_issue_ctrl;

    logic       i_clk = 1'b0;
    logic       i_rsn;
    logic       i_valid;
    logic       o_ready;
    logic [1:0] i_oper;
    logic [3:0] i_argA;
    logic [3:0] i_argB;
    logic [1:0] o_oper;
    logic [3:0] o_argA;
    logic [3:0] o_argB;
    logic [3:0] exe_result;
    logic [1:0] exe_status;
    logic       o_res_valid;
    logic       i_res_ready;
    logic [3:0] o_result;
    logic [1:0] o_status;
    logic [2:0] o_level;
    logic [7:0] o_err_cnt;

    int compared   = 0;
    int mismatched = 0;
    logic [5:0] expQ [$];
    logic [5:0] monExp;

    exe_issue_ctrl #(.m(4), .n(2), .DEPTH(4), .CW(8)) dut (
        .i_clk        (i_clk),
        .i_rsn        (i_rsn),
        .i_valid      (i_valid),
        .o_ready      (o_ready),
        .i_oper       (i_oper),
        .i_argA       (i_argA),
        .i_argB       (i_argB),
        .o_oper       (o_oper),
        .o_argA       (o_argA),
        .o_argB       (o_argB),
        .i_exe_result (exe_result),
        .i_exe_status (exe_status),
        .o_res_valid  (o_res_valid),
        .i_res_ready  (i_res_ready),
        .o_result     (o_result),
        .o_status     (o_status),
        .o_level      (o_level),
        .o_err_cnt    (o_err_cnt)
    );

    // Clock.
    always #5 i_clk = ~i_clk;

    // Registered execution unit stub.
    always @(posedge i_clk) begin
        exe_result <= o_argA ^ o_argB;
        exe_status <= (o_oper == 2'b11) ? 2'b01 : 2'b00;
    end

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        compared++;
        if (act !== exp) begin
            mismatched++;
            $display("[TB] FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Monitor: compares each accepted result against the scoreboard head.
    always @(negedge i_clk) begin
        if (i_rsn && o_res_valid && i_res_ready) begin
            if (expQ.size() == 0) begin
                compared++;
                mismatched++;
                $display("[TB] FAIL unexpected_result: got %0h with empty scoreboard at %0t", o_result, $time);
            end else begin
                monExp = expQ.pop_front();
                checkOutput("sb_result", 32'(o_result), 32'(monExp[3:0]));
                checkOutput("sb_status", 32'(o_status), 32'(monExp[5:4]));
            end
        end
    end

    task automatic syncDrive();
        @(posedge i_clk);
        #1;
    endtask

    // Offer one request, hold it until accepted, record its expected response.
    task automatic applyStimulus(input logic [1:0] op, input logic [3:0] a, input logic [3:0] b,
                                 input logic [3:0] expRes, input logic [1:0] expStat);
        int n = 0;
        i_valid = 1'b1;
        i_oper  = op;
        i_argA  = a;
        i_argB  = b;
        @(negedge i_clk);
        while (!o_ready && n < 200) begin
            @(negedge i_clk);
            n++;
        end
        if (!o_ready) begin
            checkOutput("push_timeout", 32'(o_ready), 32'd1);
        end else begin
            expQ.push_back({expStat, expRes});
        end
        @(posedge i_clk);
        #1;
        i_valid = 1'b0;
    endtask

    task automatic waitValid(input int budget);
        int n = 0;
        @(negedge i_clk);
        while (!o_res_valid && n < budget) begin
            @(negedge i_clk);
            n++;
        end
        if (!o_res_valid) begin
            checkOutput("valid_timeout", 32'(o_res_valid), 32'd1);
        end
    endtask

    task automatic waitDrain();
        int n = 0;
        @(negedge i_clk);
        while ((expQ.size() != 0 || o_res_valid || o_level != 3'd0) && n < 3000) begin
            @(negedge i_clk);
            n++;
        end
        checkOutput("drain_pending", 32'(expQ.size()), 32'd0);
    endtask

    // Directed stimulus sequence.
    initial begin
        int lv[9];
        logic [8:0] vpat;
        logic [3:0] a;
        logic [3:0] b;
        lv   = '{4, 3, 3, 2, 2, 1, 1, 0, 0};
        vpat = 9'b101010101;

        i_rsn       = 1'b0;
        i_valid     = 1'b0;
        i_oper      = '0;
        i_argA      = '0;
        i_argB      = '0;
        i_res_ready = 1'b1;
        #12;
        checkOutput("rst_ready", 32'(o_ready), 32'd1);
        checkOutput("rst_level", 32'(o_level), 32'd0);
        checkOutput("rst_valid", 32'(o_res_valid), 32'd0);
        checkOutput("rst_operands", 32'({o_oper, o_argA, o_argB}), 32'd0);
        checkOutput("rst_err", 32'(o_err_cnt), 32'd0);
        checkOutput("rst_result", 32'({o_status, o_result}), 32'd0);
        syncDrive();
        i_rsn = 1'b1;
        syncDrive();

        // Single op: valid on the third edge counting the push edge, one cycle.
        applyStimulus(2'b00, 4'h5, 4'h3, 4'h6, 2'b00);
        @(negedge i_clk);
        checkOutput("t1_level_after_push", 32'(o_level), 32'd1);
        checkOutput("t1_valid_edge1", 32'(o_res_valid), 32'd0);
        @(negedge i_clk);
        checkOutput("t1_valid_edge2", 32'(o_res_valid), 32'd0);
        checkOutput("t1_operands", 32'({o_oper, o_argA, o_argB}), 32'h053);
        @(negedge i_clk);
        checkOutput("t1_valid_edge3", 32'(o_res_valid), 32'd1);
        checkOutput("t1_result", 32'(o_result), 32'h6);
        @(negedge i_clk);
        checkOutput("t1_valid_drop", 32'(o_res_valid), 32'd0);
        checkOutput("t1_level_end", 32'(o_level), 32'd0);

        // Backpressure: result and operands stay frozen while not accepted.
        syncDrive();
        i_res_ready = 1'b0;
        applyStimulus(2'b00, 4'h5, 4'h3, 4'h6, 2'b00);
        waitValid(10);
        for (int i = 0; i < 5; i++) begin
            checkOutput("t2_hold_valid", 32'(o_res_valid), 32'd1);
            checkOutput("t2_hold_result", 32'({o_status, o_result}), 32'h06);
            checkOutput("t2_hold_operands", 32'({o_oper, o_argA, o_argB}), 32'h053);
            @(negedge i_clk);
        end
        syncDrive();
        i_res_ready = 1'b1;
        @(negedge i_clk);
        @(negedge i_clk);
        checkOutput("t2_accepted", 32'(o_res_valid), 32'd0);

        // FIFO full: five pushes under backpressure, sixth request held.
        syncDrive();
        i_res_ready = 1'b0;
        applyStimulus(2'b01, 4'h1, 4'h2, 4'h3, 2'b00);
        applyStimulus(2'b10, 4'hA, 4'h5, 4'hF, 2'b00);
        applyStimulus(2'b00, 4'hF, 4'hF, 4'h0, 2'b00);
        applyStimulus(2'b01, 4'h8, 4'h1, 4'h9, 2'b00);
        applyStimulus(2'b10, 4'hC, 4'h3, 4'hF, 2'b00);
        @(negedge i_clk);
        checkOutput("t3_level_full", 32'(o_level), 32'd4);
        checkOutput("t3_ready_full", 32'(o_ready), 32'd0);
        fork
            applyStimulus(2'b00, 4'h7, 4'h2, 4'h5, 2'b00);
            begin
                repeat (3) begin
                    @(negedge i_clk);
                    checkOutput("t3_held_ready", 32'(o_ready), 32'd0);
                    checkOutput("t3_held_level", 32'(o_level), 32'd4);
                end
                syncDrive();
                i_res_ready = 1'b1;
            end
        join
        waitDrain();

        // Throughput: four queued ops drain one result every two cycles.
        syncDrive();
        i_res_ready = 1'b0;
        applyStimulus(2'b00, 4'h1, 4'h1, 4'h0, 2'b00);
        applyStimulus(2'b01, 4'h2, 4'h4, 4'h6, 2'b00);
        applyStimulus(2'b10, 4'h3, 4'h5, 4'h6, 2'b00);
        applyStimulus(2'b00, 4'h9, 4'h6, 4'hF, 2'b00);
        applyStimulus(2'b01, 4'hE, 4'h1, 4'hF, 2'b00);
        waitValid(10);
        checkOutput("t4_level_start", 32'(o_level), 32'd4);
        syncDrive();
        i_res_ready = 1'b1;
        for (int i = 0; i < 9; i++) begin
            @(negedge i_clk);
            checkOutput("t4_valid_pattern", 32'(o_res_valid), 32'(vpat[i]));
            checkOutput("t4_level_pattern", 32'(o_level), 32'(lv[i]));
        end
        @(negedge i_clk);
        checkOutput("t4_idle", 32'(o_res_valid), 32'd0);

        // Error count: three flagged results, then saturation at 8'hFF.
        syncDrive();
        applyStimulus(2'b11, 4'h1, 4'h2, 4'h3, 2'b01);
        applyStimulus(2'b00, 4'h4, 4'h4, 4'h0, 2'b00);
        applyStimulus(2'b11, 4'h6, 4'h3, 4'h5, 2'b01);
        applyStimulus(2'b11, 4'hF, 4'h0, 4'hF, 2'b01);
        waitDrain();
        checkOutput("t5_err_three", 32'(o_err_cnt), 32'd3);
        syncDrive();
        for (int i = 0; i < 252; i++) begin
            a = 4'(i);
            b = 4'(i >> 4);
            applyStimulus(2'b11, a, b, a ^ b, 2'b01);
        end
        waitDrain();
        checkOutput("t5_err_at_max", 32'(o_err_cnt), 32'd255);
        syncDrive();
        for (int i = 0; i < 3; i++) begin
            applyStimulus(2'b11, 4'hA, 4'(i), 4'hA ^ 4'(i), 2'b01);
        end
        waitDrain();
        checkOutput("t5_err_saturated", 32'(o_err_cnt), 32'd255);

        // Reset mid-operation: outputs clear at once, nothing stale emerges.
        syncDrive();
        i_res_ready = 1'b0;
        applyStimulus(2'b00, 4'h1, 4'h2, 4'h3, 2'b00);
        applyStimulus(2'b00, 4'h3, 4'h4, 4'h7, 2'b00);
        applyStimulus(2'b00, 4'h5, 4'h6, 4'h3, 2'b00);
        waitValid(10);
        checkOutput("t6_level_before", 32'(o_level), 32'd2);
        syncDrive();
        i_rsn = 1'b0;
        #1;
        checkOutput("t6_rst_valid", 32'(o_res_valid), 32'd0);
        checkOutput("t6_rst_level", 32'(o_level), 32'd0);
        checkOutput("t6_rst_ready", 32'(o_ready), 32'd1);
        checkOutput("t6_rst_operands", 32'({o_oper, o_argA, o_argB}), 32'd0);
        checkOutput("t6_rst_err", 32'(o_err_cnt), 32'd0);
        checkOutput("t6_rst_result", 32'({o_status, o_result}), 32'd0);
        expQ.delete();
        syncDrive();
        i_rsn       = 1'b1;
        i_res_ready = 1'b1;
        for (int i = 0; i < 8; i++) begin
            @(negedge i_clk);
            checkOutput("t6_no_stale", 32'(o_res_valid), 32'd0);
        end
        checkOutput("t6_level_after", 32'(o_level), 32'd0);
        syncDrive();
        applyStimulus(2'b10, 4'h6, 4'h3, 4'h5, 2'b00);
        waitDrain();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

    // Global watchdog.
    initial begin
        #2000000;
        $display("[TB] FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

endmodule
